// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage.
//
// Owns the PC and fetches one word at a time from instruction memory. The
// request side is a valid/ready handshake. The response side has a valid
// only, with no ready. Each fetched word is held in a one-entry output
// register for decode. A branch or jump redirect flushes the stage, and any
// response still in flight is then thrown away. At most one request is
// outstanding at any time.
//
// Ports:
//   clk_i              clock; all state updates on the rising edge
//   rst_ni             asynchronous active-low reset
//   imem_req_valid_o   fetch request valid
//   imem_req_ready_i   memory accepts the request this cycle
//   imem_req_addr_o    word-aligned fetch address
//   imem_rsp_valid_i   instruction word returned this cycle
//   imem_rsp_data_i    returned instruction word
//   redirect_valid_i   taken branch/jump: flush and refetch
//   redirect_pc_i      new PC (bits [1:0] ignored)
//   id_valid_o         id_ins_o/id_pc_o hold a valid instruction
//   id_ready_i         decode consumes when id_valid_o & id_ready_i
//   id_ins_o           instruction to decode
//   id_pc_o            address of id_ins_o
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_ins_o,
  output logic [31:0] id_pc_o
);

  // StIdle: may issue. StWait: awaiting response. StDrop: response to discard.
  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_ins_q, id_ins_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic        req_hs;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  // Only issue when the output register is empty or being drained this cycle,
  // so it is guaranteed free when the response lands.
  assign imem_req_valid_o = (state_q == StIdle) && (!id_valid_q || id_ready_i);
  assign imem_req_addr_o  = pc_q;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;

  assign id_valid_o = id_valid_q;
  assign id_ins_o   = id_ins_q;
  assign id_pc_o    = id_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    id_valid_d = id_valid_q;
    id_ins_d   = id_ins_q;
    id_pc_d    = id_pc_q;

    if (id_valid_q && id_ready_i) begin
      id_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid_i) begin
          id_ins_d   = imem_rsp_data_i;
          id_pc_d    = req_pc_q;
          id_valid_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StDrop: begin
        if (imem_rsp_valid_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides everything above; id_ins/id_pc keep their old value.
    if (redirect_valid_i) begin
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      id_valid_d = 1'b0;
      id_ins_d   = id_ins_q;
      id_pc_d    = id_pc_q;
      unique case (state_q)
        StIdle:  state_d = req_hs ? StDrop : StIdle;
        StWait:  state_d = imem_rsp_valid_i ? StIdle : StDrop;
        StDrop:  state_d = imem_rsp_valid_i ? StIdle : StDrop;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      id_valid_q <= 1'b0;
      id_ins_q   <= NOP_INS;
      id_pc_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      id_valid_q <= id_valid_d;
      id_ins_q   <= id_ins_d;
      id_pc_q    <= id_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_000C;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = 32'h0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_ins_o;
  logic [31:0] id_pc_o;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_PC(RST_PC),
    .NOP_INS (NOP)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o (imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i (imem_rsp_data_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .id_valid_o      (id_valid_o),
    .id_ready_i      (id_ready_i),
    .id_ins_o        (id_ins_o),
    .id_pc_o         (id_pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Contents of the random-test instruction memory.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    #1;
    checks++;
    if (id_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid_o);
    end
    checks++;
    if (id_ins_o !== NOP) begin
      errors++; $display("FAIL reset_id_ins: got %h expected %h", id_ins_o, NOP);
    end
    checks++;
    if (id_pc_o !== 32'h0) begin
      errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc_o);
    end
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RST_PC) begin
      errors++;
      $display("FAIL reset_req: got v=%b a=%h expected v=1 a=%h",
               imem_req_valid_o, imem_req_addr_o, RST_PC);
    end
  endtask

  task automatic test_first_fetch;
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL wait_no_req: got %b expected 0", imem_req_valid_o);
    end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0012_8293;
    tick();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b1 || id_ins_o !== 32'h0012_8293 || id_pc_o !== 32'h0C) begin
      errors++;
      $display("FAIL first_fetch: got v=%b ins=%h pc=%h expected v=1 ins=00128293 pc=0000000c",
               id_valid_o, id_ins_o, id_pc_o);
    end
    checks++;
    if (imem_req_addr_o !== 32'h10) begin
      errors++; $display("FAIL next_addr: got %h expected 00000010", imem_req_addr_o);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (imem_req_valid_o !== 1'b0 || id_ins_o !== 32'h0012_8293 || id_pc_o !== 32'h0C) begin
        errors++;
        $display("FAIL stall_%0d: got rv=%b ins=%h pc=%h expected rv=0 ins=00128293 pc=0000000c",
                 i, imem_req_valid_o, id_ins_o, id_pc_o);
      end
      tick();
    end
    id_ready_i = 1'b1;
    #1;
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h10) begin
      errors++;
      $display("FAIL release_req: got v=%b a=%h expected v=1 a=00000010",
               imem_req_valid_o, imem_req_addr_o);
    end
    imem_req_ready_i = 1'b1;
    tick();
    id_ready_i       = 1'b0;
    imem_req_ready_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b0) begin
      errors++; $display("FAIL consumed: got %b expected 0", id_valid_o);
    end
  endtask

  task automatic test_redirect_wait;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h7F;
    tick();
    redirect_valid_i = 1'b0;
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL drop_no_req: got %b expected 0", imem_req_valid_o);
    end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b0 || id_ins_o !== 32'h0012_8293) begin
      errors++;
      $display("FAIL stale_dropped: got v=%b ins=%h expected v=0 ins=00128293",
               id_valid_o, id_ins_o);
    end
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h7C) begin
      errors++;
      $display("FAIL redirect_addr: got v=%b a=%h expected v=1 a=0000007c",
               imem_req_valid_o, imem_req_addr_o);
    end
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h001E_8E93;
    tick();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b1 || id_ins_o !== 32'h001E_8E93 || id_pc_o !== 32'h7C) begin
      errors++;
      $display("FAIL redirect_fetch: got v=%b ins=%h pc=%h expected v=1 ins=001e8e93 pc=0000007c",
               id_valid_o, id_ins_o, id_pc_o);
    end
  endtask

  task automatic test_redirect_with_rsp;
    id_ready_i       = 1'b1;
    imem_req_ready_i = 1'b1;
    tick();
    id_ready_i       = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h1234_5678;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h100;
    tick();
    imem_rsp_valid_i = 1'b0;
    redirect_valid_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b0 || id_ins_o !== 32'h001E_8E93) begin
      errors++;
      $display("FAIL rsp_redirect_drop: got v=%b ins=%h expected v=0 ins=001e8e93",
               id_valid_o, id_ins_o);
    end
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL rsp_redirect_addr: got v=%b a=%h expected v=1 a=00000100",
               imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  task automatic test_wrap;
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'hFFFF_FFFC;
    tick();
    redirect_valid_i = 1'b0;
    checks++;
    if (imem_req_addr_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_req_addr_o);
    end
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0000_0093;
    tick();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 32'hFFFF_FFFC || id_ins_o !== 32'h0000_0093) begin
      errors++;
      $display("FAIL wrap_first: got v=%b pc=%h ins=%h expected v=1 pc=fffffffc ins=00000093",
               id_valid_o, id_pc_o, id_ins_o);
    end
    checks++;
    if (imem_req_addr_o !== 32'h0) begin
      errors++; $display("FAIL wrap_next_addr: got %h expected 00000000", imem_req_addr_o);
    end
    id_ready_i       = 1'b1;
    imem_req_ready_i = 1'b1;
    tick();
    id_ready_i       = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h0010_0113;
    tick();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_ins_o !== 32'h0010_0113) begin
      errors++;
      $display("FAIL wrap_second: got v=%b pc=%h ins=%h expected v=1 pc=00000000 ins=00100113",
               id_valid_o, id_pc_o, id_ins_o);
    end
  endtask

  task automatic test_reset_mid_wait;
    id_ready_i       = 1'b1;
    imem_req_ready_i = 1'b1;
    tick();
    id_ready_i       = 1'b0;
    imem_req_ready_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (id_valid_o !== 1'b0 || id_ins_o !== NOP || id_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got v=%b ins=%h pc=%h expected v=0 ins=%h pc=0",
               id_valid_o, id_ins_o, id_pc_o, NOP);
    end
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RST_PC) begin
      errors++;
      $display("FAIL async_reset_req: got v=%b a=%h expected v=1 a=%h",
               imem_req_valid_o, imem_req_addr_o, RST_PC);
    end
    tick();
    rst_ni           = 1'b1;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hBADC_0DE5;
    tick();
    imem_rsp_valid_i = 1'b0;
    checks++;
    if (id_valid_o !== 1'b0 || id_ins_o !== NOP) begin
      errors++;
      $display("FAIL late_rsp_ignored: got v=%b ins=%h expected v=0 ins=%h",
               id_valid_o, id_ins_o, NOP);
    end
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RST_PC) begin
      errors++;
      $display("FAIL late_rsp_req: got v=%b a=%h expected v=1 a=%h",
               imem_req_valid_o, imem_req_addr_o, RST_PC);
    end
  endtask

  // Random traffic against a program-order model: decode must see consecutive
  // words from the current PC, restarting at each redirect target.
  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] paddr;
    logic [31:0] target;
    logic        pending;
    logic        pend_before;
    logic        redir;
    int unsigned cnt;
    int          delivered;

    imem_req_ready_i = 1'b0;
    id_ready_i       = 1'b0;
    rst_ni           = 1'b0;
    tick();
    rst_ni    = 1'b1;
    exp_pc    = RST_PC;
    pending   = 1'b0;
    paddr     = 32'h0;
    cnt       = 0;
    delivered = 0;

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk_i);
      id_ready_i       = ($urandom_range(0, 3) != 0);
      imem_req_ready_i = ($urandom_range(0, 2) != 0);
      redir            = ($urandom_range(0, 24) == 0);
      target           = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                     : $urandom;
      redirect_valid_i = redir;
      redirect_pc_i    = target;

      pend_before      = pending;
      imem_rsp_valid_i = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          imem_rsp_valid_i = 1'b1;
          imem_rsp_data_i  = mem_word(paddr);
          pending          = 1'b0;
        end else begin
          cnt--;
        end
      end
      #1;

      if (imem_req_valid_o && imem_req_ready_i) begin
        checks++;
        if (pend_before || imem_req_addr_o[1:0] !== 2'b00) begin
          errors++;
          $display("FAIL rand_issue: got outstanding=%b addr=%h expected outstanding=0 aligned",
                   pend_before, imem_req_addr_o);
        end
        pending = 1'b1;
        cnt     = $urandom_range(0, 2);
        paddr   = imem_req_addr_o;
      end

      if (id_valid_o && id_ready_i) begin
        checks++;
        if (id_pc_o !== exp_pc || id_ins_o !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rand_deliver: got pc=%h ins=%h expected pc=%h ins=%h",
                   id_pc_o, id_ins_o, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end

      if (redir) exp_pc = {target[31:2], 2'b00};
    end

    @(negedge clk_i);
    imem_rsp_valid_i = 1'b0;
    redirect_valid_i = 1'b0;
    checks++;
    if (delivered < 200) begin
      errors++; $display("FAIL rand_progress: got %0d deliveries expected >= 200", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_with_rsp();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
